// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle RV32 subset controller.
// Opcodes, ALU operation codes and the FSM state encoding.
package mc_pkg;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_ST  = 7'h23;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    // beq (funct3 000) and bne (funct3 001) are the only supported branches
    function automatic logic br_taken(input logic [2:0] funct3, input logic zero);
        return (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational decode of opcode/funct3/funct7 into ALU controls.
// Also flags opcodes (and branch funct3 values) the datapath cannot execute.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       illegal_op
);

    always_comb begin
        alu_op     = ALU_ADD;
        alu_src    = 1'b1;
        illegal_op = 1'b0;
        case (opcode)
            OP_R: begin
                alu_src = 1'b0;
                case (funct3)
                    3'b000:  alu_op = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_I: begin
                case (funct3)
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_LD, OP_ST, OP_JAL: alu_op = ALU_ADD;
            OP_BR: begin
                alu_src    = 1'b0;
                alu_op     = ALU_SUB;
                illegal_op = (funct3 != 3'b000) && (funct3 != 3'b001);
            end
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM and PC register for the RV32 subset datapath.
// Controls are Moore outputs of state and the latched instruction.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 'h28,
    parameter int unsigned      CNT_W    = 32,
    parameter bit               MEM_HS   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  pcp4,
    input  logic [XLEN-1:0]  branch_tgt,
    input  logic [XLEN-1:0]  jump_tgt,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      ir,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem2reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_load;
    logic             retire;
    logic [2:0]       dec_alu_op;
    logic             dec_alu_src;
    logic             dec_illegal;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign is_load = (opcode == OP_LD);

    mc_alu_dec u_alu_dec (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (ir_q[31:25]),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .illegal_op (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        instret_d = instret_q;
        retire    = 1'b0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        mem2reg   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_op    = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                ir_d    = ins;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                if (opcode == OP_LD || opcode == OP_ST) begin
                    state_d = S_MEM;
                end else if (opcode == OP_BR) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_read  = is_load;
                mem_write = !is_load;
                if (mem_ready || !MEM_HS) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                mem2reg   = is_load;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
            if (opcode == OP_JAL) begin
                pc_d = jump_tgt;
            end else if (opcode == OP_BR && br_taken(funct3, zero)) begin
                pc_d = branch_tgt;
            end else begin
                pc_d = pcp4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a 4-bit retire counter and MEM handshake.
// Expected PC and retire count are tracked by the bench from hand-computed values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] ins;
    logic        zero;
    logic        mem_ready;
    logic [31:0] pcp4;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        reg_write, alu_src, mem2reg, mem_read, mem_write;
    logic [2:0]  alu_op;
    logic [2:0]  state;
    logic        illegal;
    logic [3:0]  instret;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_pc;
    logic [3:0]  exp_cnt;

    multicycle_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h28),
        .CNT_W    (4),
        .MEM_HS   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ins        (ins),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcp4       (pcp4),
        .branch_tgt (branch_tgt),
        .jump_tgt   (jump_tgt),
        .pc         (pc),
        .ir         (ir),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .mem2reg    (mem2reg),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
        .state      (state),
        .illegal    (illegal),
        .instret    (instret)
    );

    assign pcp4 = pc + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // R-type / I-ALU / jal style: FETCH, DECODE, EXEC, WB
    task automatic run_alu(input logic [31:0] i, input logic [2:0] op, input logic src);
        ins = i;
        chk("alu_fetch_state", 32'(state), 32'd0);
        tick;
        chk("alu_decode_state", 32'(state), 32'd1);
        chk("alu_ir", ir, i);
        chk("alu_decode_rw", 32'(reg_write), 32'd0);
        tick;
        chk("alu_exec_state", 32'(state), 32'd2);
        chk("alu_op", 32'(alu_op), 32'(op));
        chk("alu_src", 32'(alu_src), 32'(src));
        chk("alu_exec_rw", 32'(reg_write), 32'd0);
        tick;
        chk("alu_wb_state", 32'(state), 32'd4);
        chk("alu_wb_rw", 32'(reg_write), 32'd1);
        chk("alu_wb_m2r", 32'(mem2reg), 32'd0);
        chk("alu_wb_pc_hold", pc, exp_pc);
        tick;
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 4'd1;
        chk("alu_retire_state", 32'(state), 32'd0);
        chk("alu_retire_pc", pc, exp_pc);
        chk("alu_retire_cnt", 32'(instret), 32'(exp_cnt));
        chk("alu_retire_rw", 32'(reg_write), 32'd0);
    endtask

    task automatic run_br(input logic [31:0] i, input logic z, input logic [31:0] tgt,
                          input logic [31:0] next_pc);
        ins        = i;
        zero       = z;
        branch_tgt = tgt;
        tick;
        chk("br_decode_state", 32'(state), 32'd1);
        tick;
        chk("br_exec_state", 32'(state), 32'd2);
        chk("br_alu_op", 32'(alu_op), 32'b110);
        chk("br_alu_src", 32'(alu_src), 32'd0);
        chk("br_pc_hold", pc, exp_pc);
        tick;
        exp_pc  = next_pc;
        exp_cnt = exp_cnt + 4'd1;
        chk("br_retire_state", 32'(state), 32'd0);
        chk("br_retire_pc", pc, exp_pc);
        chk("br_retire_cnt", 32'(instret), 32'(exp_cnt));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n   = 1'b1;
        exp_pc  = 32'h28;
        exp_cnt = 4'd0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ins        = 32'h0;
        zero       = 1'b0;
        mem_ready  = 1'b0;
        branch_tgt = 32'h0;
        jump_tgt   = 32'h0;
        exp_pc     = 32'h28;
        exp_cnt    = 4'd0;
        tick;
        tick;
        chk("rst_pc", pc, 32'h28);
        chk("rst_ir", ir, 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);

        // sw stalled in MEM, then reset lands mid-wait
        rst_n = 1'b1;
        ins   = 32'h00552023;
        tick;
        tick;
        chk("sw_exec_src", 32'(alu_src), 32'd1);
        tick;
        chk("sw_mem_state", 32'(state), 32'd3);
        chk("sw_mem_write", 32'(mem_write), 32'd1);
        tick;
        chk("sw_mem_wait", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_pc", pc, 32'h28);
        chk("midrst_instret", 32'(instret), 32'd0);
        chk("midrst_mem_write", 32'(mem_write), 32'd0);

        // R-type and I-type ALU decode
        run_alu(32'h00B50633, 3'b010, 1'b0);
        run_alu(32'h40B50633, 3'b110, 1'b0);
        run_alu(32'h00B57633, 3'b000, 1'b0);
        run_alu(32'h00B56633, 3'b001, 1'b0);
        run_alu(32'h00B52633, 3'b111, 1'b0);
        run_alu(32'h00108093, 3'b010, 1'b1);
        run_alu(32'h0010F093, 3'b000, 1'b1);
        run_alu(32'h0010E093, 3'b001, 1'b1);
        run_alu(32'h0010A093, 3'b111, 1'b1);

        // lw with mem_ready low for three MEM cycles: 8 cycles total
        ins       = 32'h00052283;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        chk("lw_decode_state", 32'(state), 32'd1);
        tick;
        chk("lw_exec_op", 32'(alu_op), 32'b010);
        chk("lw_exec_src", 32'(alu_src), 32'd1);
        chk("lw_exec_rd", 32'(mem_read), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("lw_mem_state", 32'(state), 32'd3);
            chk("lw_mem_read", 32'(mem_read), 32'd1);
            chk("lw_mem_pc", pc, exp_pc);
        end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_m2r", 32'(mem2reg), 32'd1);
        chk("lw_wb_rw", 32'(reg_write), 32'd1);
        chk("lw_wb_rd", 32'(mem_read), 32'd0);
        tick;
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 4'd1;
        chk("lw_retire_pc", pc, exp_pc);
        chk("lw_retire_cnt", 32'(instret), 32'(exp_cnt));

        // sw with mem_ready already high when MEM is entered: 4 cycles
        ins       = 32'h00552023;
        mem_ready = 1'b1;
        tick;
        tick;
        tick;
        chk("sw1_mem_state", 32'(state), 32'd3);
        chk("sw1_mem_write", 32'(mem_write), 32'd1);
        tick;
        mem_ready = 1'b0;
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 4'd1;
        chk("sw1_retire_state", 32'(state), 32'd0);
        chk("sw1_retire_pc", pc, exp_pc);
        chk("sw1_retire_cnt", 32'(instret), 32'(exp_cnt));
        chk("sw1_write_off", 32'(mem_write), 32'd0);

        // branches
        run_br(32'h00B50063, 1'b1, 32'h40, 32'h40);
        run_br(32'h00B50063, 1'b0, 32'h90, 32'h44);
        run_br(32'h00B51063, 1'b0, 32'h80, 32'h80);
        run_br(32'h00B51063, 1'b1, 32'hC0, 32'h84);

        // jal: counter wraps 15 -> 0 here
        jump_tgt = 32'h100;
        ins      = 32'h008000EF;
        tick;
        tick;
        chk("jal_src", 32'(alu_src), 32'd1);
        tick;
        chk("jal_wb_rw", 32'(reg_write), 32'd1);
        tick;
        exp_pc  = 32'h100;
        exp_cnt = exp_cnt + 4'd1;
        chk("jal_pc", pc, exp_pc);
        chk("jal_cnt_wrap", 32'(instret), 32'd0);

        // illegal opcode: absorbing HALT
        ins = 32'h0000007F;
        tick;
        chk("ill_decode_flag", 32'(illegal), 32'd0);
        tick;
        chk("ill_state", 32'(state), 32'd7);
        chk("ill_flag", 32'(illegal), 32'd1);
        for (int k = 0; k < 20; k++) begin
            mem_ready = k[0];
            ins       = 32'h00B50633;
            tick;
            chk("halt_state", 32'(state), 32'd7);
            chk("halt_pc", pc, exp_pc);
            chk("halt_cnt", 32'(instret), 32'(exp_cnt));
            chk("halt_wr", 32'({reg_write, mem_write}), 32'd0);
        end
        mem_ready = 1'b0;

        // unsupported branch funct3 also halts
        do_reset;
        chk("rst2_illegal", 32'(illegal), 32'd0);
        chk("rst2_state", 32'(state), 32'd0);
        ins = 32'h00B52063;
        tick;
        tick;
        chk("illbr_state", 32'(state), 32'd7);
        chk("illbr_flag", 32'(illegal), 32'd1);
        chk("illbr_pc", pc, 32'h28);

        // 17 retired addi with a 4-bit counter
        do_reset;
        for (int k = 0; k < 17; k++) begin
            run_alu(32'h00108093, 3'b010, 1'b1);
        end
        chk("wrap17_instret", 32'(instret), 32'd1);
        chk("wrap17_pc", pc, 32'h28 + 32'd68);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
